// File: rtl/ball_packet_i2c_tx.sv
// I2C master write of a ball-state or win packet to the peer board's register bank.
// SCL/SDA are open-drain: *_oe = 1 pulls the line low.
module ball_packet_i2c_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         CLK_DIV    = 63
) (
  input  logic       clk_25MHZ,
  input  logic       reset_n,
  input  logic       send_ball,
  input  logic       send_win,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       speed_slow,
  input  logic       win_flag,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  localparam logic [9:0] DivLast = 10'(CLK_DIV - 1);

  state_t      state_q;
  logic [9:0]  div_q;
  logic [9:0]  div_d;
  logic [1:0]  qtr_q;
  logic [2:0]  bit_q;
  logic [2:0]  byte_q;
  logic [2:0]  last_q;
  logic [63:0] buf_q;
  logic        busy_q;
  logic        done_q;
  logic        ack_error_q;
  logic        scl_oe_q;
  logic        sda_oe_q;

  logic        tick;
  logic [7:0]  curByte;
  logic [63:0] ballPacket;
  logic [63:0] winPacket;

  // The byte being sent always sits in the top of the buffer; it shifts up one byte per ACK.
  assign ballPacket = {SLAVE_ADDR, 1'b0, 8'h00, ball_y[9:8], 6'b0, ball_y[7:0], ball_vy,
                       6'b0, gravity_counter, 7'b0, speed_slow, 8'h00};
  assign winPacket  = {SLAVE_ADDR, 1'b0, 8'h05, 7'b0, win_flag, 40'h0};
  assign curByte    = buf_q[63:56];
  assign tick       = (div_q == DivLast);
  assign div_d      = tick ? 10'd0 : div_q + 10'd1;

  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      last_q      <= '0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE || state_q == DONE) begin
        div_q <= '0;
        qtr_q <= '0;
      end else begin
        div_q <= div_d;
        if (tick) qtr_q <= qtr_q + 2'd1;
      end

      case (state_q)
        IDLE: begin
          if (send_ball || send_win) begin
            state_q     <= START;
            busy_q      <= 1'b1;
            ack_error_q <= 1'b0;
            byte_q      <= '0;
            bit_q       <= 3'd7;
            buf_q       <= send_ball ? ballPacket : winPacket;
            last_q      <= send_ball ? 3'd7 : 3'd2;
          end
        end

        START: begin
          if (tick) begin
            case (qtr_q)
              2'd0: begin
                scl_oe_q <= 1'b0;
                sda_oe_q <= 1'b0;
              end
              2'd1: sda_oe_q <= 1'b1;
              2'd2: scl_oe_q <= 1'b1;
              default: begin
                state_q <= BIT;
                byte_q  <= '0;
                bit_q   <= 3'd7;
              end
            endcase
          end
        end

        BIT: begin
          if (tick) begin
            case (qtr_q)
              2'd0: begin
                scl_oe_q <= 1'b1;
                sda_oe_q <= ~curByte[bit_q];
              end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: scl_oe_q <= 1'b0;
              default: begin
                scl_oe_q <= 1'b1;
                if (bit_q == 3'd0) state_q <= ACK;
                else               bit_q   <= bit_q - 3'd1;
              end
            endcase
          end
        end

        // ack_error was cleared at acceptance, so it doubles as "this byte was NACKed".
        ACK: begin
          if (tick) begin
            case (qtr_q)
              2'd0: begin
                sda_oe_q <= 1'b0;
                scl_oe_q <= 1'b1;
              end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: if (sda_i) ack_error_q <= 1'b1;
              default: begin
                scl_oe_q <= 1'b1;
                if (ack_error_q || byte_q == last_q) begin
                  state_q <= STOP;
                end else begin
                  state_q <= BIT;
                  byte_q  <= byte_q + 3'd1;
                  bit_q   <= 3'd7;
                  buf_q   <= buf_q << 8;
                end
              end
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            case (qtr_q)
              2'd0: begin
                sda_oe_q <= 1'b1;
                scl_oe_q <= 1'b1;
              end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: sda_oe_q <= 1'b0;
              default: begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_ball_packet_i2c_tx.sv
// Bench for ball_packet_i2c_tx: a bus monitor/slave decodes SCL/SDA and compares
// received bytes against a packet model built from the input values.
module tb_ball_packet_i2c_tx;

  localparam logic [6:0] SlaveAddr   = 7'h42;
  localparam int         CycleBudget = 6000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       send_ball;
  logic       send_win;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       speed_slow;
  logic       win_flag;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;

  int errors = 0;
  int checks = 0;

  logic       slaveDrive = 1'b0;
  logic       sclPrev = 1'b1;
  logic       sdaPrev = 1'b1;
  logic       inXfer = 1'b0;
  int         falls = 0;
  int         nackByte = -1;
  int         startCnt = 0;
  int         stopCnt = 0;
  int         doneCnt = 0;
  logic       curBits[$];
  logic [7:0] expBytes[$];

  ball_packet_i2c_tx #(.SLAVE_ADDR(SlaveAddr), .CLK_DIV(4)) dut (
    .clk_25MHZ(clk), .reset_n(reset_n), .send_ball(send_ball), .send_win(send_win),
    .ball_y(ball_y), .ball_vy(ball_vy), .gravity_counter(gravity_counter),
    .speed_slow(speed_slow), .win_flag(win_flag), .busy(busy), .done(done),
    .ack_error(ack_error), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #20 clk = ~clk;

  assign sda_i = ~(sda_oe | slaveDrive);

  // Bus monitor and ACKing slave; SCL rises record bits, the rise belonging to STOP is dropped.
  always @(negedge clk) begin
    logic sclNow;
    logic sdaNow;
    sclNow = ~scl_oe;
    sdaNow = ~(sda_oe | slaveDrive);
    if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
      startCnt++;
      inXfer = 1'b1;
      curBits.delete();
      falls = 0;
    end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
      stopCnt++;
      if (inXfer && curBits.size() > 0) void'(curBits.pop_back());
      inXfer = 1'b0;
    end
    if (inXfer && !sclPrev && sclNow) curBits.push_back(sdaNow);
    if (inXfer && sclPrev && !sclNow) begin
      falls++;
      slaveDrive = (falls >= 1) && (((falls - 1) % 9) == 8) && (((falls - 1) / 9) != nackByte);
    end
    if (done) doneCnt++;
    sclPrev = sclNow;
    sdaPrev = sdaNow;
  end

  function automatic void modelBall(input logic [9:0] y, input logic [7:0] vy,
                                    input logic [1:0] g, input logic s);
    expBytes.delete();
    expBytes.push_back({SlaveAddr, 1'b0});
    expBytes.push_back(8'h00);
    expBytes.push_back({y[9:8], 6'b0});
    expBytes.push_back(y[7:0]);
    expBytes.push_back(vy);
    expBytes.push_back({6'b0, g});
    expBytes.push_back({7'b0, s});
    expBytes.push_back(8'h00);
  endfunction

  function automatic void modelWin(input logic wf);
    expBytes.delete();
    expBytes.push_back({SlaveAddr, 1'b0});
    expBytes.push_back(8'h05);
    expBytes.push_back({7'b0, wf});
  endfunction

  function automatic logic [7:0] rxByte(input int idx);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      if (idx * 9 + b < curBits.size()) v[7 - b] = curBits[idx * 9 + b];
    end
    return v;
  endfunction

  task automatic sendReq(input logic b, input logic w);
    @(posedge clk); #1;
    send_ball = b;
    send_win  = w;
    @(posedge clk); #1;
    send_ball = 1'b0;
    send_win  = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CycleBudget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    send_ball = 1'b0;
    send_win = 1'b0;
    ball_y = '0;
    ball_vy = '0;
    gravity_counter = '0;
    speed_slow = 1'b0;
    win_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackerr got %b want 0", ack_error); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_scl got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda got %b want 0", sda_oe); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ball_packet;
    bit ok;
    int sb, pb, db;
    ball_y = 10'h2D5;
    ball_vy = 8'hFD;
    gravity_counter = 2'd2;
    speed_slow = 1'b1;
    modelBall(ball_y, ball_vy, gravity_counter, speed_slow);
    sb = startCnt; pb = stopCnt; db = doneCnt;
    sendReq(1'b1, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ball_busy_after_accept got %b want 1", busy); end
    waitDone(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ball_done_timeout got 0 want 1"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ball_busy_in_done got %b want 1", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ball_done_width got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ball_busy_after_done got %b want 0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (doneCnt - db !== 1) begin errors++; $display("[TB] FAIL ball_done_count got %0d want 1", doneCnt - db); end
    checks++; if (curBits.size() !== 72) begin errors++; $display("[TB] FAIL ball_scl_pulses got %0d want 72", curBits.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (rxByte(i) !== expBytes[i]) begin
        errors++; $display("[TB] FAIL ball_byte%0d got %h want %h", i, rxByte(i), expBytes[i]);
      end
    end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("[TB] FAIL ball_ackerr got %b want 0", ack_error); end
    checks++; if (startCnt - sb !== 1) begin errors++; $display("[TB] FAIL ball_start_conds got %0d want 1", startCnt - sb); end
    checks++; if (stopCnt - pb !== 1) begin errors++; $display("[TB] FAIL ball_stop_conds got %0d want 1", stopCnt - pb); end
  endtask

  task automatic test_win_packet;
    bit ok;
    int sb, pb;
    win_flag = 1'b1;
    modelWin(win_flag);
    sb = startCnt; pb = stopCnt;
    sendReq(1'b0, 1'b1);
    waitDone(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL win_done_timeout got 0 want 1"); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL win_done_width got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL win_busy_after_done got %b want 0", busy); end
    repeat (5) @(negedge clk);
    checks++; if (curBits.size() !== 27) begin errors++; $display("[TB] FAIL win_scl_pulses got %0d want 27", curBits.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (rxByte(i) !== expBytes[i]) begin
        errors++; $display("[TB] FAIL win_byte%0d got %h want %h", i, rxByte(i), expBytes[i]);
      end
    end
    checks++; if (startCnt - sb !== 1 || stopCnt - pb !== 1) begin
      errors++; $display("[TB] FAIL win_start_stop got %0d/%0d want 1/1", startCnt - sb, stopCnt - pb);
    end
  endtask

  task automatic test_both_requests;
    bit ok;
    int db;
    ball_y = 10'(($urandom % 1024));
    ball_vy = 8'($urandom % 256);
    gravity_counter = 2'($urandom % 4);
    speed_slow = 1'($urandom % 2);
    win_flag = 1'b1;
    modelBall(ball_y, ball_vy, gravity_counter, speed_slow);
    db = doneCnt;
    sendReq(1'b1, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < CycleBudget; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        send_win = 1'b0;
        break;
      end
      send_win = ((k % 40) < 2);
    end
    send_win = 1'b0;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL both_done_timeout got 0 want 1"); end
    repeat (20) @(negedge clk);
    checks++; if (doneCnt - db !== 1) begin errors++; $display("[TB] FAIL both_done_count got %0d want 1", doneCnt - db); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL both_busy_idle got %b want 0", busy); end
    checks++; if (curBits.size() !== 72) begin errors++; $display("[TB] FAIL both_scl_pulses got %0d want 72", curBits.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (rxByte(i) !== expBytes[i]) begin
        errors++; $display("[TB] FAIL both_byte%0d got %h want %h", i, rxByte(i), expBytes[i]);
      end
    end
  endtask

  task automatic test_nack;
    bit ok;
    int pb, db;
    nackByte = 0;
    ball_y = 10'h155;
    ball_vy = 8'h12;
    pb = stopCnt; db = doneCnt;
    sendReq(1'b1, 1'b0);
    waitDone(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nack_done_timeout got 0 want 1"); end
    repeat (5) @(negedge clk);
    checks++; if (ack_error !== 1'b1) begin errors++; $display("[TB] FAIL nack_ackerr got %b want 1", ack_error); end
    checks++; if (curBits.size() !== 9) begin errors++; $display("[TB] FAIL nack_scl_pulses got %0d want 9", curBits.size()); end
    checks++; if (rxByte(0) !== {SlaveAddr, 1'b0}) begin errors++; $display("[TB] FAIL nack_addr got %h want %h", rxByte(0), {SlaveAddr, 1'b0}); end
    checks++; if (stopCnt - pb !== 1) begin errors++; $display("[TB] FAIL nack_stop got %0d want 1", stopCnt - pb); end
    checks++; if (doneCnt - db !== 1) begin errors++; $display("[TB] FAIL nack_done_count got %0d want 1", doneCnt - db); end
    nackByte = -1;
    win_flag = 1'b0;
    modelWin(win_flag);
    sendReq(1'b0, 1'b1);
    @(negedge clk);
    checks++; if (ack_error !== 1'b0) begin errors++; $display("[TB] FAIL nack_clear_on_accept got %b want 0", ack_error); end
    waitDone(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nack_retry_timeout got 0 want 1"); end
    repeat (5) @(negedge clk);
    checks++; if (ack_error !== 1'b0) begin errors++; $display("[TB] FAIL nack_retry_ackerr got %b want 0", ack_error); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (rxByte(i) !== expBytes[i]) begin
        errors++; $display("[TB] FAIL nack_retry_byte%0d got %h want %h", i, rxByte(i), expBytes[i]);
      end
    end
  endtask

  task automatic test_reset_midxfer;
    bit ok;
    int db;
    ball_y = 10'h3A7;
    ball_vy = 8'h80;
    sendReq(1'b1, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < CycleBudget; k++) begin
      @(negedge clk);
      if (curBits.size() >= 30) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_reach_byte3 got 0 want 1"); end
    db = doneCnt;
    #7 reset_n = 1'b0;
    #1;
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_lines got scl=%b sda=%b want 0/0", scl_oe, sda_oe);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (doneCnt - db !== 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d want 0", doneCnt - db); end
    ball_y = 10'h0F3;
    ball_vy = 8'h7E;
    gravity_counter = 2'd1;
    speed_slow = 1'b0;
    modelBall(ball_y, ball_vy, gravity_counter, speed_slow);
    sendReq(1'b1, 1'b0);
    waitDone(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_fresh_timeout got 0 want 1"); end
    repeat (5) @(negedge clk);
    checks++; if (curBits.size() !== 72) begin errors++; $display("[TB] FAIL midrst_scl_pulses got %0d want 72", curBits.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (rxByte(i) !== expBytes[i]) begin
        errors++; $display("[TB] FAIL midrst_byte%0d got %h want %h", i, rxByte(i), expBytes[i]);
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    bit isBall;
    for (int n = 0; n < 6; n++) begin
      isBall = 1'($urandom % 2);
      ball_y = 10'($urandom % 1024);
      ball_vy = 8'($urandom % 256);
      gravity_counter = 2'($urandom % 4);
      speed_slow = 1'($urandom % 2);
      win_flag = 1'($urandom % 2);
      if (isBall) modelBall(ball_y, ball_vy, gravity_counter, speed_slow);
      else        modelWin(win_flag);
      sendReq(isBall, ~isBall);
      ball_y = ~ball_y;
      ball_vy = ~ball_vy;
      gravity_counter = ~gravity_counter;
      speed_slow = ~speed_slow;
      win_flag = ~win_flag;
      waitDone(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout got 0 want 1", n); end
      repeat (5) @(negedge clk);
      checks++; if (curBits.size() !== 9 * expBytes.size()) begin
        errors++; $display("[TB] FAIL rand%0d_scl_pulses got %0d want %0d", n, curBits.size(), 9 * expBytes.size());
      end
      for (int i = 0; i < expBytes.size(); i++) begin
        checks++;
        if (rxByte(i) !== expBytes[i]) begin
          errors++; $display("[TB] FAIL rand%0d_byte%0d got %h want %h", n, i, rxByte(i), expBytes[i]);
        end
      end
      checks++; if (ack_error !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_ackerr got %b want 0", n, ack_error); end
    end
  endtask

  initial begin
    test_reset();
    test_ball_packet();
    test_win_packet();
    test_both_requests();
    test_nack();
    test_reset_midxfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
